note_score_tracker: RTL and testbench
=====================================

# note_score_tracker

Scores live pitch detection against the song's expected note stream. It takes the song sequencer's note-window strobes and the FFT pitch detector's one-hot note flags. It awards a hit once per window when the expected note is held long enough, and flags a miss when a window closes unhit. It keeps a saturating score with a streak multiplier and drives the display and score readout. It generalises the fixed 12-flag score updater: note count, widths, debounce length and scoring are parameters, and it adds windowing, debounce, miss detection and streaks.

## Interface
- NUM_NOTES, 12, number of detectable pitch classes (one-hot width)
- NOTE_W, 4, width of note code; code 0 = rest, codes 1..NUM_NOTES map to note_onehot bit code-1
- SCORE_W, 64, score accumulator width
- HIT_CYCLES, 4, consecutive matching cycles required for a hit (≥1)
- POINTS, 10, base points per hit
- STREAK_W, 8, streak counter width
- STREAK_STEP, 4, hits per multiplier increment
- MAX_MULT, 4, multiplier ceiling
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- note_start  in  1  one-cycle strobe: open a new window for expected_note
- note_end  in  1  one-cycle strobe: close current window
- expected_note  in  NOTE_W  expected note code, sampled on note_start
- note_onehot  in  NUM_NOTES  detected notes from FFT, sampled every cycle
- hit  out  1  one-cycle pulse on hit award
- miss  out  1  one-cycle pulse when a scored window closes unhit
- score  out  SCORE_W  accumulated score
- streak  out  STREAK_W  consecutive-hit count
- mult  out  3  current multiplier
- note  out  NOTE_W  expected note of the open window (0 when idle or rest)

## Operation
- FSM states:
  - IDLE: no window.
  - REST: window open, code 0 or out of range.
  - ARMED: window open, counting matches.
  - SCORED: hit awarded, waiting for close.
- note_start in any state opens a new window. Valid code → ARMED; code 0 or >NUM_NOTES → REST.
- note_end alone → IDLE.
- Closing an ARMED window, whether by note_end or by a new note_start, emits miss and clears streak. Closing REST or SCORED emits nothing.
- Match counter (width clog2(HIT_CYCLES+1)):
  - In ARMED, increments when note_onehot[note-1]=1; clears to 0 when that bit is 0.
  - Other bits are ignored.
  - Clears on every window open.
- Counter reaching HIT_CYCLES: hit=1, score += POINTS×mult (mult value before this hit), streak +1, state → SCORED. Award happens once per window.
- mult = min(1 + streak/STREAK_STEP, MAX_MULT).
- score saturates at all-ones; streak saturates at all-ones.
- Simultaneous note_start and note_end: note_start wins. Treated as close then open.
- Hit threshold reached in the same cycle as a close: the close wins. No hit, miss emitted.

## Timing
- Reset values: state IDLE, hit=0, miss=0, score=0, streak=0, mult=1, note=0, counter=0.
- note_start at edge t: note and state valid after t. First match sample is at edge t+1.
- Minimum hit latency: hit is high in the cycle after the HIT_CYCLES-th consecutive matching edge. With HIT_CYCLES=4 and the bit held from note_start onward, hit is asserted during cycle t+5.
- score, streak and mult update on the same edge that raises hit. miss and the streak clear share one edge.
- Reset asserted mid-window clears everything immediately and asynchronously. No miss is emitted.

## Configuration
- SCORE_STREAK_EN defined: streak counting and multiplier as above.
- Not defined:
  - streak held at 0, mult tied to 1.
  - Every hit adds exactly POINTS.
  - miss and hit behaviour unchanged.

## Test plan
Parameters: HIT_CYCLES=4, POINTS=10, STREAK_STEP=4, MAX_MULT=4, SCORE_STREAK_EN defined.
- Reset, then note_start with expected_note=1 and note_onehot=12'h001 held → one hit pulse 5 cycles after note_start; score=10, streak=1, no second hit before note_end.
- expected_note=3, bit 2 toggled 3-on/1-off repeatedly until note_end → no hit; miss pulse on note_end; streak=0; score unchanged.
- Eight consecutive hit windows → scores add 10,10,10,10,20,20,20,20; final score=120, streak=8, mult=3.
- Rest window (code 0) between hits, with note_onehot all ones → no hit, no miss, streak preserved.
- note_start with a new note while ARMED and unhit → miss pulse in the same cycle; new note shown on note; counter restarted.
- Preload score near all-ones (SCORE_W=8), then hit → score saturates at 8'hFF. Reset mid-window → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/note_score_tracker_if.sv
// ---------------------------------------------------------------------------
// note_score_tracker_if
//
// Groups the signals between the song sequencer / pitch detector and the
// note score tracker. It also carries the score readout and display signals.
//
// Signals:
//   note_start     sequencer strobe: open a window for expected_note
//   note_end       sequencer strobe: close the current window
//   expected_note  note code of the window being opened (0 = rest)
//   note_onehot    one-hot pitch flags from the FFT detector
//   hit / miss     one-cycle scoring pulses
//   score          saturating score accumulator
//   streak         consecutive-hit count
//   mult           current score multiplier
//   note           expected note of the open window (0 when idle or rest)
//
// Modports: master drives the strobes and flags; slave is the tracker.
// ---------------------------------------------------------------------------
interface note_score_tracker_if #(
    parameter int NUM_NOTES = 12,
    parameter int NOTE_W    = 4,
    parameter int SCORE_W   = 64,
    parameter int STREAK_W  = 8
);
    logic                 note_start;
    logic                 note_end;
    logic [NOTE_W-1:0]    expected_note;
    logic [NUM_NOTES-1:0] note_onehot;
    logic                 hit;
    logic                 miss;
    logic [SCORE_W-1:0]   score;
    logic [STREAK_W-1:0]  streak;
    logic [2:0]           mult;
    logic [NOTE_W-1:0]    note;

    modport master (
        output note_start, note_end, expected_note, note_onehot,
        input  hit, miss, score, streak, mult, note
    );

    modport slave (
        input  note_start, note_end, expected_note, note_onehot,
        output hit, miss, score, streak, mult, note
    );
endinterface

// File: rtl/note_score_tracker.sv
// ---------------------------------------------------------------------------
// note_score_tracker
//
// Scores live pitch detection against the expected note stream. The
// sequencer opens and closes note windows. Within a window, the expected
// note's flag must be seen on HIT_CYCLES consecutive cycles to earn a hit.
// A hit is awarded at most once per window. A window that closes unhit
// raises miss. The score saturates. A streak counter drives a score
// multiplier.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset (clears all state, no miss)
//   bus    note_score_tracker_if.slave
//          inputs : note_start, note_end, expected_note, note_onehot
//          outputs: hit, miss, score, streak, mult, note
//
// Configuration macro:
//   SCORE_STREAK_EN  defined     -> streak counting and multiplier enabled
//                    not defined -> streak held at 0, mult fixed at 1,
//                                   every hit adds exactly POINTS
// ---------------------------------------------------------------------------
module note_score_tracker #(
    parameter int NUM_NOTES   = 12,
    parameter int NOTE_W      = 4,
    parameter int SCORE_W     = 64,
    parameter int HIT_CYCLES  = 4,
    parameter int POINTS      = 10,
    parameter int STREAK_W    = 8,
    parameter int STREAK_STEP = 4,
    parameter int MAX_MULT    = 4
) (
    input logic                 clk,
    input logic                 reset,
    note_score_tracker_if.slave bus
);

    localparam int CNT_W = $clog2(HIT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REST,
        S_ARMED,
        S_SCORED
    } state_t;

    state_t              state_q, state_nxt;
    logic [NOTE_W-1:0]   note_q, note_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic [SCORE_W-1:0]  score_q, score_nxt;
    logic [STREAK_W-1:0] streak_q, streak_nxt;
    logic                hit_q, hit_nxt;
    logic                miss_q, miss_nxt;
    logic [2:0]          mult_w;
    logic                match_w;
    logic                code_ok_w;

    // min(1 + streak/STREAK_STEP, MAX_MULT)
    function automatic logic [2:0] calc_mult(input logic [STREAK_W-1:0] s);
        int m;
        m = 1 + int'(s) / STREAK_STEP;
        if (m > MAX_MULT)
            m = MAX_MULT;
        return 3'(m);
    endfunction

    // Score accumulate with saturation at all-ones.
    function automatic logic [SCORE_W-1:0] sat_add_score(
        input logic [SCORE_W-1:0] acc,
        input logic [2:0]         m
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, acc} + (SCORE_W + 1)'(POINTS * int'(m));
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

    // Streak increment with saturation at all-ones.
    function automatic logic [STREAK_W-1:0] sat_inc_streak(
        input logic [STREAK_W-1:0] s
    );
        return (s == '1) ? s : s + 1'b1;
    endfunction

`ifdef SCORE_STREAK_EN
    assign mult_w = calc_mult(streak_q);
`else
    assign mult_w = calc_mult('0);
`endif

    // Only the expected note's flag matters; other pitches are ignored.
    always_comb begin
        match_w = 1'b0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (int'(note_q) == i + 1)
                match_w = bus.note_onehot[i];
        end
    end

    assign code_ok_w = (bus.expected_note != '0) &&
                       (int'(bus.expected_note) <= NUM_NOTES);

    // Next-state and output logic
    always_comb begin
        state_nxt  = state_q;
        note_nxt   = note_q;
        cnt_nxt    = cnt_q;
        score_nxt  = score_q;
        streak_nxt = streak_q;
        hit_nxt    = 1'b0;
        miss_nxt   = 1'b0;

        // Any close of an unhit scored window is a miss. A start counts as
        // a close. A close outranks a hit due on the same edge.
        if ((bus.note_start || bus.note_end) && state_q == S_ARMED) begin
            miss_nxt   = 1'b1;
            streak_nxt = '0;
        end

        if (bus.note_start) begin
            cnt_nxt = '0;
            if (code_ok_w) begin
                state_nxt = S_ARMED;
                note_nxt  = bus.expected_note;
            end else begin
                state_nxt = S_REST;
                note_nxt  = '0;
            end
        end else if (bus.note_end) begin
            state_nxt = S_IDLE;
            note_nxt  = '0;
            cnt_nxt   = '0;
        end else if (state_q == S_ARMED) begin
            if (match_w) begin
                if (cnt_q == CNT_W'(HIT_CYCLES - 1)) begin
                    // This edge is the HIT_CYCLES-th consecutive match.
                    // Use the multiplier from before this hit.
                    hit_nxt   = 1'b1;
                    state_nxt = S_SCORED;
                    cnt_nxt   = CNT_W'(HIT_CYCLES);
                    score_nxt = sat_add_score(score_q, mult_w);
`ifdef SCORE_STREAK_EN
                    streak_nxt = sat_inc_streak(streak_q);
`else
                    streak_nxt = '0;
`endif
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end else begin
                cnt_nxt = '0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            note_q   <= '0;
            cnt_q    <= '0;
            score_q  <= '0;
            streak_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            note_q   <= note_nxt;
            cnt_q    <= cnt_nxt;
            score_q  <= score_nxt;
            streak_q <= streak_nxt;
            hit_q    <= hit_nxt;
            miss_q   <= miss_nxt;
        end
    end

    assign bus.hit    = hit_q;
    assign bus.miss   = miss_q;
    assign bus.score  = score_q;
    assign bus.streak = streak_q;
    assign bus.mult   = mult_w;
    assign bus.note   = note_q;

endmodule

// File: tb/tb_note_score_tracker.sv
// Testbench for note_score_tracker: a 64-bit-score instance and an 8-bit-score
// instance share the same stimulus and are compared with a window-level model.
module tb_note_score_tracker;

    localparam int HIT  = 4;
    localparam int PTS  = 10;
    localparam int STEP = 4;
    localparam int MAXM = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    note_score_tracker_if #(.NUM_NOTES(12), .NOTE_W(4), .SCORE_W(64), .STREAK_W(8)) bus ();
    note_score_tracker_if #(.NUM_NOTES(12), .NOTE_W(4), .SCORE_W(8),  .STREAK_W(8)) bus_s ();

    note_score_tracker #(
        .NUM_NOTES(12), .NOTE_W(4), .SCORE_W(64), .HIT_CYCLES(HIT), .POINTS(PTS),
        .STREAK_W(8), .STREAK_STEP(STEP), .MAX_MULT(MAXM)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    note_score_tracker #(
        .NUM_NOTES(12), .NOTE_W(4), .SCORE_W(8), .HIT_CYCLES(HIT), .POINTS(PTS),
        .STREAK_W(8), .STREAK_STEP(STEP), .MAX_MULT(MAXM)
    ) u_small (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_s)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: one open window at a time
    bit          armed;      // window open, valid note, not yet hit
    int          m_code;     // note shown on the display
    int          run;        // consecutive matching samples in this window
    longint      m_score;    // unbounded score (never near 2^63 here)
    int          m_streak;
    bit          exp_hit;
    bit          exp_miss;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int mult_of(input int s);
`ifdef SCORE_STREAK_EN
        int m;
        m = 1 + s / STEP;
        return (m > MAXM) ? MAXM : m;
`else
        return 1;
`endif
    endfunction

    task automatic model_reset();
        armed = 0; m_code = 0; run = 0; m_score = 0; m_streak = 0;
        exp_hit = 0; exp_miss = 0;
    endtask

    task automatic model_edge(input bit ns, input bit ne, input int code, input logic [11:0] oh);
        exp_hit  = 0;
        exp_miss = 0;
        if ((ns || ne) && armed) begin
            exp_miss = 1;
            m_streak = 0;
        end
        if (ns) begin
            run = 0;
            if (code >= 1 && code <= 12) begin
                armed = 1; m_code = code;
            end else begin
                armed = 0; m_code = 0;
            end
        end else if (ne) begin
            armed = 0; m_code = 0;
        end else if (armed) begin
            run = oh[m_code-1] ? run + 1 : 0;
            if (run == HIT) begin
                exp_hit = 1;
                m_score += longint'(PTS * mult_of(m_streak));
`ifdef SCORE_STREAK_EN
                if (m_streak < 255) m_streak++;
`endif
                armed = 0;
            end
        end
    endtask

    task automatic compare_all();
        longint small_exp;
        small_exp = (m_score > 255) ? 255 : m_score;
        check("hit",    64'(bus.hit),    64'(exp_hit));
        check("miss",   64'(bus.miss),   64'(exp_miss));
        check("score",  bus.score,       64'(m_score));
        check("streak", 64'(bus.streak), 64'(m_streak));
        check("mult",   64'(bus.mult),   64'(mult_of(m_streak)));
        check("note",   64'(bus.note),   64'(m_code));
        check("score8", 64'(bus_s.score), 64'(small_exp));
        check("hit8",   64'(bus_s.hit),   64'(exp_hit));
    endtask

    task automatic drive(input bit ns, input bit ne, input logic [3:0] code, input logic [11:0] oh);
        bus.note_start   = ns; bus.note_end   = ne; bus.expected_note   = code; bus.note_onehot   = oh;
        bus_s.note_start = ns; bus_s.note_end = ne; bus_s.expected_note = code; bus_s.note_onehot = oh;
    endtask

    task automatic cycle(input bit ns, input bit ne, input logic [3:0] code, input logic [11:0] oh);
        @(negedge clk);
        drive(ns, ne, code, oh);
        @(posedge clk);
        model_edge(ns, ne, int'(code), oh);
        #1;
        compare_all();
    endtask

    // mode: 0 hold expected bit, 1 three-on/one-off, 2 random, 3 all ones
    function automatic logic [11:0] pat(input int code, input int mode, input int i);
        logic [11:0] bitv;
        bitv = (code >= 1 && code <= 12) ? (12'h001 << (code - 1)) : 12'($urandom);
        case (mode)
            0:       return bitv;
            1:       return (i % 4 != 3) ? bitv : 12'h000;
            2:       return 12'($urandom);
            default: return 12'hFFF;
        endcase
    endfunction

    // Start strobe, len-1 body cycles, then optional separate note_end.
    task automatic window(input int code, input int len, input int mode,
                          input bit end_it, input bit simul);
        cycle(1'b1, simul, 4'(code), pat(code, mode, 0));
        for (int i = 1; i < len; i++)
            cycle(1'b0, 1'b0, 4'(code), pat(code, mode, i));
        if (end_it)
            cycle(1'b0, 1'b1, 4'(code), pat(code, mode, len));
    endtask

    task automatic sync_reset_pulse();
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 12'h000);
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int hits_seen;
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 12'h000);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        // Reset values
        check("rst_score", bus.score, 64'd0);
        check("rst_mult",  64'(bus.mult), 64'd1);
        check("rst_note",  64'(bus.note), 64'd0);
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        // Held note: exactly one hit, four edges after the start edge
        hits_seen = 0;
        cycle(1'b1, 1'b0, 4'd1, 12'h001);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b0, 4'd1, 12'h001);
            if (bus.hit) begin
                hits_seen++;
                check("hit_latency", 64'(i), 64'(HIT));
            end
        end
        cycle(1'b0, 1'b1, 4'd1, 12'h001);
        check("one_hit", 64'(hits_seen), 64'd1);
        check("score_10", bus.score, 64'd10);

        // Toggled note never reaches the threshold; close raises miss
        window(3, 12, 1, 1'b1, 1'b0);
        check("miss_on_end", 64'(bus.miss), 64'd1);
        check("streak_cleared", 64'(bus.streak), 64'd0);
        check("score_kept", bus.score, 64'd10);

        // Eight consecutive hits from reset
        sync_reset_pulse();
        for (int w = 0; w < 8; w++)
            window(int'($urandom_range(1, 12)), 6, 0, 1'b1, 1'b0);
`ifdef SCORE_STREAK_EN
        check("eight_score",  bus.score, 64'd120);
        check("eight_streak", 64'(bus.streak), 64'd8);
        check("eight_mult",   64'(bus.mult), 64'd3);
`else
        check("eight_score",  bus.score, 64'd80);
        check("eight_streak", 64'(bus.streak), 64'd0);
        check("eight_mult",   64'(bus.mult), 64'd1);
`endif

        // Rest window with every flag set: nothing scored, streak kept
        window(0, 7, 3, 1'b1, 1'b0);
        check("rest_score", bus.score, 64'(m_score));

        // Armed window replaced by a new note before hitting
        window(5, 2, 0, 1'b0, 1'b0);
        window(7, 6, 0, 1'b1, 1'b0);

        // Randomized windows
        for (int w = 0; w < 300; w++) begin
            int r, code;
            r = int'($urandom_range(0, 19));
            if (r == 0)      code = 0;
            else if (r == 1) code = int'($urandom_range(13, 15));
            else             code = int'($urandom_range(1, 12));
            window(code, int'($urandom_range(1, 9)), int'($urandom_range(0, 3)),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 2))
                cycle(1'b0, 1'b0, 4'd0, 12'($urandom));
        end
        if (m_score >= 255)
            check("score8_sat", 64'(bus_s.score), 64'hFF);

        // Asynchronous reset mid-window
        window(2, 3, 0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_score", bus.score, 64'd0);
        check("async_note",  64'(bus.note), 64'd0);
        check("async_miss",  64'(bus.miss), 64'd0);
        compare_all();
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 12'h000);
        reset = 1'b0;
        window(4, 6, 0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
